// File: rtl/neopixel_pkg.sv
// Shared types and timing helpers for the WS281x/SK6812 chain driver.
package neopixel_pkg;

    localparam int BITS_RGB  = 24;
    localparam int BITS_RGBW = 32;

    typedef enum logic [1:0] {
        IDLE,
        FILL,
        SYM,
        LATCH
    } state_e;

    // Truncating ns -> clock cycle conversion; the /1000 first keeps the product in 32 bits.
    function automatic int ns_to_cycles(input int clk_hz, input int ns);
        return (clk_hz / 1000 * ns) / 1_000_000;
    endfunction

endpackage

// File: rtl/neopixel_symbol_gen.sv
// One WS281x symbol: high for T0H/T1H cycles, low for the rest of a TBIT period.
module neopixel_symbol_gen #(
    parameter int T0H_CYC  = 11,
    parameter int T1H_CYC  = 22,
    parameter int TBIT_CYC = 40
) (
    input  logic clock,
    input  logic reset_n,
    input  logic go,
    input  logic bit_value,
    output logic line,
    output logic last_cycle
);

    localparam int CW = $clog2(TBIT_CYC) + 1;
    localparam logic [CW-1:0] T0H_C     = CW'(T0H_CYC);
    localparam logic [CW-1:0] T1H_C     = CW'(T1H_CYC);
    localparam logic [CW-1:0] TBIT_LAST = CW'(TBIT_CYC - 1);

    logic [CW-1:0] cnt_q, cnt_d;

    // The counter wraps to 0 on the last cycle so back-to-back symbols have no gap.
    always_comb begin
        cnt_d      = '0;
        line       = 1'b0;
        last_cycle = 1'b0;
        if (go) begin
            last_cycle = (cnt_q == TBIT_LAST);
            line       = (cnt_q < (bit_value ? T1H_C : T0H_C));
            cnt_d      = last_cycle ? '0 : cnt_q + CW'(1);
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/neopixel_chain.sv
// Frame controller for a daisy-chained WS281x/SK6812 string: one-entry pixel
// prefetch buffer, MSB-first shift register, latch gap and done/underrun pulses.
module neopixel_chain
    import neopixel_pkg::*;
#(
    parameter int CLOCK_SPEED_HZ = 32_000_000,
    parameter int NUM_PIXELS     = 8,
    parameter int BITS_PER_PIXEL = BITS_RGB,
    parameter int T0H_NS         = 350,
    parameter int T1H_NS         = 700,
    parameter int TBIT_NS        = 1250,
    parameter int LATCH_US       = 80
) (
    input  logic                      clock,
    input  logic                      reset_n,
    input  logic                      start,
    input  logic [BITS_PER_PIXEL-1:0] pixel_data,
    input  logic                      pixel_valid,
    output logic                      pixel_ready,
    output logic                      busy,
    output logic                      done,
    output logic                      underrun,
    output logic                      one_wire
);

    localparam int T0H_CYC   = ns_to_cycles(CLOCK_SPEED_HZ, T0H_NS);
    localparam int T1H_CYC   = ns_to_cycles(CLOCK_SPEED_HZ, T1H_NS);
    localparam int TBIT_CYC  = ns_to_cycles(CLOCK_SPEED_HZ, TBIT_NS);
    localparam int LATCH_CYC = CLOCK_SPEED_HZ / 1_000_000 * LATCH_US;

    localparam int BW = $clog2(BITS_PER_PIXEL) + 1;
    localparam int RW = $clog2(NUM_PIXELS) + 1;
    localparam int LW = $clog2(LATCH_CYC) + 1;

    localparam logic [BW-1:0] BIT_TOP    = BW'(BITS_PER_PIXEL - 1);
    localparam logic [RW-1:0] REQ_MAX    = RW'(NUM_PIXELS);
    localparam logic [LW-1:0] LATCH_LAST = LW'(LATCH_CYC - 1);

    if (!(BITS_PER_PIXEL == BITS_RGB || BITS_PER_PIXEL == BITS_RGBW)) begin : g_bad_bpp
        $error("neopixel_chain: BITS_PER_PIXEL must be 24 or 32");
    end
    if (!(1 <= T0H_CYC && T0H_CYC < T1H_CYC && T1H_CYC < TBIT_CYC)) begin : g_bad_timing
        $error("neopixel_chain: need 1 <= T0H_CYC < T1H_CYC < TBIT_CYC");
    end
    if (NUM_PIXELS < 1) begin : g_bad_count
        $error("neopixel_chain: NUM_PIXELS must be at least 1");
    end

    state_e                    state_q, state_d;
    logic [BITS_PER_PIXEL-1:0] buf_q, buf_d;
    logic [BITS_PER_PIXEL-1:0] shreg_q, shreg_d;
    logic                      buf_full_q, buf_full_d;
    logic [BW-1:0]             bit_ctr_q, bit_ctr_d;
    logic [RW-1:0]             req_ctr_q, req_ctr_d;
    logic [LW-1:0]             latch_ctr_q, latch_ctr_d;
    logic                      abort_q, abort_d;
    logic                      busy_q, busy_d;
    logic                      done_q, done_d;
    logic                      underrun_q, underrun_d;
    logic                      ready_q, ready_d;

    logic sym_go, sym_line, sym_last, xfer;

    assign xfer   = pixel_valid & ready_q;
    assign sym_go = (state_q == SYM);

    neopixel_symbol_gen #(
        .T0H_CYC (T0H_CYC),
        .T1H_CYC (T1H_CYC),
        .TBIT_CYC(TBIT_CYC)
    ) u_sym (
        .clock     (clock),
        .reset_n   (reset_n),
        .go        (sym_go),
        .bit_value (shreg_q[BITS_PER_PIXEL-1]),
        .line      (sym_line),
        .last_cycle(sym_last)
    );

    always_comb begin
        state_d     = state_q;
        buf_d       = buf_q;
        shreg_d     = shreg_q;
        buf_full_d  = buf_full_q;
        bit_ctr_d   = bit_ctr_q;
        req_ctr_d   = req_ctr_q;
        latch_ctr_d = latch_ctr_q;
        abort_d     = abort_q;
        busy_d      = busy_q;
        done_d      = 1'b0;
        underrun_d  = 1'b0;

        // ready is only high while the buffer is empty, so this never collides with a reload.
        if (xfer) begin
            buf_d      = pixel_data;
            buf_full_d = 1'b1;
            req_ctr_d  = req_ctr_q + RW'(1);
        end

        case (state_q)
            IDLE: begin
                if (start) begin
                    state_d     = FILL;
                    busy_d      = 1'b1;
                    req_ctr_d   = '0;
                    buf_full_d  = 1'b0;
                    abort_d     = 1'b0;
                    latch_ctr_d = '0;
                end
            end
            FILL: begin
                if (buf_full_q) begin
                    shreg_d    = buf_q;
                    buf_full_d = 1'b0;
                    bit_ctr_d  = BIT_TOP;
                    state_d    = SYM;
                end
            end
            SYM: begin
                if (sym_last) begin
                    if (bit_ctr_q != '0) begin
                        shreg_d   = shreg_q << 1;
                        bit_ctr_d = bit_ctr_q - BW'(1);
                    end else if (buf_full_q) begin
                        shreg_d    = buf_q;
                        buf_full_d = 1'b0;
                        bit_ctr_d  = BIT_TOP;
                    end else begin
                        // Empty buffer: either the frame is complete or the source fell behind.
                        state_d = LATCH;
                        abort_d = (req_ctr_q != REQ_MAX);
                    end
                end
            end
            LATCH: begin
                if (latch_ctr_q == LATCH_LAST) begin
                    state_d     = IDLE;
                    busy_d      = 1'b0;
                    done_d      = ~abort_q;
                    underrun_d  = abort_q;
                    latch_ctr_d = '0;
                    buf_full_d  = 1'b0;
                end else begin
                    latch_ctr_d = latch_ctr_q + LW'(1);
                end
            end
            default: state_d = IDLE;
        endcase

        ready_d = busy_d & ~buf_full_d & (req_ctr_d < REQ_MAX) & (state_d != LATCH);
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= IDLE;
            buf_q       <= '0;
            shreg_q     <= '0;
            buf_full_q  <= 1'b0;
            bit_ctr_q   <= '0;
            req_ctr_q   <= '0;
            latch_ctr_q <= '0;
            abort_q     <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            underrun_q  <= 1'b0;
            ready_q     <= 1'b0;
        end else begin
            state_q     <= state_d;
            buf_q       <= buf_d;
            shreg_q     <= shreg_d;
            buf_full_q  <= buf_full_d;
            bit_ctr_q   <= bit_ctr_d;
            req_ctr_q   <= req_ctr_d;
            latch_ctr_q <= latch_ctr_d;
            abort_q     <= abort_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            underrun_q  <= underrun_d;
            ready_q     <= ready_d;
        end
    end

    assign pixel_ready = ready_q;
    assign busy        = busy_q;
    assign done        = done_q;
    assign underrun    = underrun_q;
    assign one_wire    = sym_line;

endmodule
